// File: rtl/modu_exp_ctrl.sv
// modu_exp_ctrl: sequential modular exponentiation controller driving an external modular multiplier.
// Optional feature macro: MODEXP_LZ_SKIP_EN (start scanning at the highest set exponent bit).
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   strobe, base/exponent/modulus  start request and operands (accepted only while idle)
//   result, ready, busy, err    base^exponent mod modulus, completion pulse, activity, modulus==0 flag
//   mul_x/mul_y/mul_m, mul_strobe  request to the multiplier (x*y mod m)
//   mul_p, mul_ready            multiplier product and completion
module modu_exp_ctrl #(
    parameter int NLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            strobe,
    input  logic [NLEN-1:0] base,
    input  logic [NLEN-1:0] exponent,
    input  logic [NLEN-1:0] modulus,
    output logic [NLEN-1:0] result,
    output logic            ready,
    output logic            busy,
    output logic            err,
    output logic [NLEN-1:0] mul_x,
    output logic [NLEN-1:0] mul_y,
    output logic [NLEN-1:0] mul_m,
    output logic            mul_strobe,
    input  logic [NLEN-1:0] mul_p,
    input  logic            mul_ready
);
    localparam int IW = (NLEN > 1) ? $clog2(NLEN) : 1;
    localparam logic [NLEN-1:0] ONE = NLEN'(1);

    typedef enum logic [2:0] {
        IDLE, RED_REQ, RED_WAIT, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, DONE
    } state_t;

    state_t state_q, state_d;
    logic [NLEN-1:0] base_q, base_d, exp_q, exp_d, mod_q, mod_d;
    logic [NLEN-1:0] rbase_q, rbase_d, acc_q, acc_d, result_q, result_d;
    logic [IW-1:0] idx_q, idx_d, start_idx;
    logic err_q, err_d;
    logic last, red, sqr, mul;

`ifdef MODEXP_LZ_SKIP_EN
    localparam bit SKIP = 1'b1;
    // Highest set exponent bit; only meaningful when exponent != 0.
    always_comb begin
        start_idx = '0;
        for (int i = 0; i < NLEN; i++)
            if (exponent[i]) start_idx = IW'(i);
    end
`else
    localparam bit SKIP = 1'b0;
    assign start_idx = IW'(NLEN - 1);
`endif

    assign last = idx_q == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            rbase_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            rbase_q  <= rbase_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (strobe) state_d = (modulus == '0 || exponent == '0) ? DONE : RED_REQ;
            RED_REQ:  state_d = RED_WAIT;
            RED_WAIT: if (mul_ready) state_d = (SKIP && last) ? DONE : SQR_REQ;
            SQR_REQ:  state_d = SQR_WAIT;
            SQR_WAIT: if (mul_ready) state_d = exp_q[idx_q] ? MUL_REQ : last ? DONE : SQR_REQ;
            MUL_REQ:  state_d = MUL_WAIT;
            MUL_WAIT: if (mul_ready) state_d = last ? DONE : SQR_REQ;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        base_d   = base_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        rbase_d  = rbase_q;
        acc_d    = acc_q;
        result_d = result_q;
        idx_d    = idx_q;
        err_d    = err_q;
        if (state_q == IDLE && strobe) begin
            base_d   = base;
            exp_d    = exponent;
            mod_d    = modulus;
            acc_d    = ONE;
            idx_d    = start_idx;
            err_d    = modulus == '0;
            // Trivial cases finish without the multiplier, so their result is set here.
            result_d = modulus == '0 ? '0 : exponent == '0 ? (modulus == ONE ? '0 : ONE) : result_q;
        end
        if (mul_ready && (state_q == RED_WAIT || state_q == SQR_WAIT || state_q == MUL_WAIT)) begin
            rbase_d  = state_q == RED_WAIT ? mul_p : rbase_q;
            // Without skipping, the reduction does not consume an exponent bit and acc stays 1.
            acc_d    = (state_q != RED_WAIT || SKIP) ? mul_p : acc_q;
            result_d = state_d == DONE ? mul_p : result_q;
            idx_d    = (state_d == SQR_REQ && (state_q != RED_WAIT || SKIP)) ? idx_q - IW'(1) : idx_q;
        end
    end

    assign red = state_q == RED_REQ || state_q == RED_WAIT;
    assign sqr = state_q == SQR_REQ || state_q == SQR_WAIT;
    assign mul = state_q == MUL_REQ || state_q == MUL_WAIT;

    always_comb begin
        mul_strobe = state_q == RED_REQ || state_q == SQR_REQ || state_q == MUL_REQ;
        mul_x      = red ? base_q : (sqr || mul) ? acc_q : '0;
        mul_y      = red ? ONE : sqr ? acc_q : mul ? rbase_q : '0;
        mul_m      = (red || sqr || mul) ? mod_q : '0;
        ready      = state_q == DONE;
        busy       = state_q != IDLE;
        result     = result_q;
        err        = err_q;
    end
endmodule

// File: tb/tb_modu_exp_ctrl.sv
// tb_modu_exp_ctrl: scoreboard bench for modu_exp_ctrl with a 3-cycle modular multiplier model.
module tb_modu_exp_ctrl;
    localparam int NLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            strobe = 1'b0;
    logic [NLEN-1:0] base = '0, exponent = '0, modulus = '0, mul_p = '0;
    logic            mul_ready = 1'b0;
    logic [NLEN-1:0] result, mul_x, mul_y, mul_m;
    logic            ready, busy, err, mul_strobe;

    modu_exp_ctrl #(.NLEN(NLEN)) dut (
        .clk(clk), .rst(rst), .strobe(strobe), .base(base), .exponent(exponent),
        .modulus(modulus), .result(result), .ready(ready), .busy(busy), .err(err),
        .mul_x(mul_x), .mul_y(mul_y), .mul_m(mul_m), .mul_strobe(mul_strobe),
        .mul_p(mul_p), .mul_ready(mul_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NLEN-1:0] res;
        logic            err;
        int              cnt;
        int              st;
    } exp_t;

    exp_t            sb[$];
    int              n_vec = 0, n_err = 0, nstrb = 0, lat = 0;
    logic [NLEN-1:0] px, py, pm;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [NLEN-1:0] ref_exp(input logic [NLEN-1:0] b, e, m);
        logic [63:0] r, x, mm;
        if (m == 0) return '0;
        mm = 64'(m);
        r  = 64'd1 % mm;
        x  = 64'(b) % mm;
        for (int i = 0; i < NLEN; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return NLEN'(r);
    endfunction

    function automatic int ref_cnt(input logic [NLEN-1:0] e, m);
        int msb = 0;
        if (m == 0 || e == 0) return 0;
        for (int i = 0; i < NLEN; i++) if (e[i]) msb = i;
`ifdef MODEXP_LZ_SKIP_EN
        return msb + $countones(e);
`else
        return 1 + NLEN + $countones(e);
`endif
    endfunction

    // Multiplier model plus output monitor, all on the falling edge.
    always @(negedge clk) begin
        exp_t x;
        logic [63:0] t;
        mul_ready = 1'b0;
        if (lat > 0) begin
            lat--;
            if (lat == 0) begin
                t = (pm == 0) ? 64'd0 : (64'(px) * 64'(py)) % 64'(pm);
                mul_p = NLEN'(t);
                mul_ready = 1'b1;
                if (busy) chk("mul_operands_stable", {mul_x, mul_y}, {px, py});
            end
        end
        if (mul_strobe) begin
            px = mul_x;
            py = mul_y;
            pm = mul_m;
            lat = 3;
            nstrb++;
        end
        if (ready) begin
            if (sb.size() == 0) chk("spurious_ready", 1, 0);
            else begin
                x = sb.pop_front();
                chk("result", result, x.res);
                chk("err", err, x.err);
                chk("mul_strobe_count", nstrb - x.st, x.cnt);
            end
        end
    end

    task automatic start(input logic [NLEN-1:0] b, e, m);
        exp_t x;
        @(negedge clk);
        base = b;
        exponent = e;
        modulus = m;
        strobe = 1'b1;
        x.res = ref_exp(b, e, m);
        x.err = (m == 0);
        x.cnt = ref_cnt(e, m);
        x.st = nstrb;
        sb.push_back(x);
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [NLEN-1:0] b, e, m);
        start(b, e, m);
        drain();
    endtask

    initial begin
        int st;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {result, ready, busy, err, mul_strobe}, 0);
        chk("rst_mul_xym", {mul_x | mul_y | mul_m}, 0);
        rst = 1'b0;

        run(4, 13, 497);
        start(20, 2, 7);
        for (int i = 0; i < 20 && !mul_ready; i++) @(posedge clk);
        chk("reduced_base", mul_p, 6);
        drain();
        run(3, 0, 7);
        run(3, 0, 1);
        run(9, 5, 0);
        run(7, 1, 13);
        run(32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFB);

        start(5, 3, 13);
        repeat (6) @(negedge clk);
        base = 2;
        exponent = 9;
        modulus = 11;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        chk("busy_during_op", busy, 1);
        drain();
        repeat (20) @(negedge clk);

        st = nstrb;
        start(5, 3, 13);
        for (int i = 0; i < 50 && nstrb - st < 2; i++) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("rst_abandon_busy", busy, 0);
        repeat (8) @(negedge clk);
        chk("stray_mul_ready_busy", busy, 0);
        run(5, 3, 13);

        @(negedge clk);
        rst = 1'b1;
        strobe = 1'b1;
        base = 5;
        exponent = 3;
        modulus = 13;
        @(negedge clk);
        chk("rst_priority_busy", busy, 0);
        rst = 1'b0;
        strobe = 1'b0;
        @(negedge clk);
        chk("rst_priority_idle", busy, 0);

        for (int k = 0; k < 8; k++)
            run($urandom, $urandom_range(0, 300), k == 0 ? $urandom : $urandom_range(1, 5000));
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
